// File: rtl/mux_arbiter.sv
// -----------------------------------------------------------------------------
// mux_arbiter
//
// Round-robin arbiter for four requesters that share one 4:1 multiplexer.
// A winner gets a one-hot grant and drives the mux select lines.
// It keeps the grant until one of these happens:
//   - it signals done,
//   - it drops its request, or
//   - it has held the grant for MAX_HOLD cycles.
// Every grant ends with exactly one RELEASE cycle, which has no grant.
// Search order after a release starts just past the released requester,
// so the previous holder has lowest priority on the next arbitration.
//
// Parameters
//   MAX_HOLD  maximum consecutive grant cycles per holder (1..255)
//
// Ports
//   clk                clock, all state changes on the rising edge
//   reset_n            asynchronous active-low reset
//   req0..req3         requests from requesters 0..3
//   done               holder finished; only looked at while a grant is held
//   addr0, addr1       mux select, {addr1,addr0} = granted index
//   gnt0..gnt3         one-hot grant to requesters 0..3
//   busy               high while any grant is high
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module mux_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic req0,
  input  logic req1,
  input  logic req2,
  input  logic req3,
  input  logic done,
  output logic addr0,
  output logic addr1,
  output logic gnt0,
  output logic gnt1,
  output logic gnt2,
  output logic gnt3,
  output logic busy
);

  // Wide enough to hold MAX_HOLD itself.
  localparam int CW = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [3:0]      gnt_reg,   gnt_next;
  logic [1:0]      addr_reg,  addr_next;
  logic            busy_reg,  busy_next;
  logic [CW-1:0]   cnt_reg,   cnt_next;
  logic [1:0]      last_reg,  last_next;

  logic [3:0]      req_vec;
  logic [3:0]      rot_req;
  logic [1:0]      win_off;
  logic            win_valid;
  logic [1:0]      winner;
  logic            holder_req;
  logic            hold_full;

  assign req_vec = {req3, req2, req1, req0};

  // Rotate the request vector so that bit 0 is the requester just after
  // the last released holder. A fixed priority pick on rot_req then gives
  // round-robin order.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rot
      logic [1:0] cand;
      assign cand        = last_reg + 2'(gi + 1);
      assign rot_req[gi] = req_vec[cand];
    end
  endgenerate

  // The lowest set bit of the rotated vector wins.
  always_comb begin
    win_off = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (rot_req[i]) begin
        win_off = 2'(i);
      end
    end
  end

  assign win_valid = |rot_req;
  assign winner    = last_reg + 2'd1 + win_off;

  // addr_reg always holds the current holder's index while in GRANT.
  assign holder_req = req_vec[addr_reg];
  assign hold_full  = (cnt_reg == CW'(MAX_HOLD));

  // Next-state and next-output logic
  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    addr_next  = addr_reg;
    busy_next  = busy_reg;
    cnt_next   = cnt_reg;
    last_next  = last_reg;

    case (state_reg)
      // IDLE and RELEASE arbitrate identically.
      // RELEASE already sees the updated last_reg, so a pending request is
      // granted on the very next edge without passing through IDLE.
      IDLE, RELEASE: begin
        if (win_valid) begin
          state_next = GRANT;
          gnt_next   = 4'b0001 << winner;
          addr_next  = winner;
          busy_next  = 1'b1;
          cnt_next   = CW'(1);
        end else begin
          state_next = IDLE;
          gnt_next   = 4'b0000;
          busy_next  = 1'b0;
        end
      end

      GRANT: begin
        // Every exit cause funnels into the same single transition.
        // So coincident causes still give one RELEASE and one update of last.
        if (done || !holder_req || hold_full) begin
          state_next = RELEASE;
          gnt_next   = 4'b0000;
          busy_next  = 1'b0;
          last_next  = addr_reg;
        end else begin
          // Not full here, so the increment cannot pass MAX_HOLD or wrap.
          cnt_next = cnt_reg + CW'(1);
        end
      end

      default: begin
        state_next = IDLE;
        gnt_next   = 4'b0000;
        busy_next  = 1'b0;
      end
    endcase
  end

  // State register
  // last resets to 3 so that requester 0 is searched first after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      gnt_reg   <= 4'b0000;
      addr_reg  <= 2'd0;
      busy_reg  <= 1'b0;
      cnt_reg   <= '0;
      last_reg  <= 2'd3;
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      addr_reg  <= addr_next;
      busy_reg  <= busy_next;
      cnt_reg   <= cnt_next;
      last_reg  <= last_next;
    end
  end

  assign gnt0  = gnt_reg[0];
  assign gnt1  = gnt_reg[1];
  assign gnt2  = gnt_reg[2];
  assign gnt3  = gnt_reg[3];
  assign addr0 = addr_reg[0];
  assign addr1 = addr_reg[1];
  assign busy  = busy_reg;

endmodule
